// File: rtl/cn_ff_ctrl_pkg.sv
// Shared types for the CN flip-flop controller: opcodes, FSM states and
// the width of the post-reset clear counter.
package cn_ff_ctrl_pkg;

  localparam int INIT_CNT_W = 4;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_SET    = 3'd1,
    OP_CLEAR  = 3'd2,
    OP_TOGGLE = 3'd3,
    OP_WRITE  = 3'd4,
    OP_PULSE  = 3'd5
  } cn_op_e;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_PULSE2 = 3'd3,
    ST_CHECK  = 3'd4
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= 3'd5);
  endfunction

  // The first phase of PULSE behaves as SET; illegal codes degrade to NOP.
  function automatic logic [2:0] issue_op(input logic [2:0] op);
    logic [2:0] res;
    case (op)
      OP_PULSE: res = OP_SET;
      3'd6, 3'd7: res = OP_NOP;
      default: res = op;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cn_ff_ctrl_if.sv
// Command and flip-flop-facing bus of the CN flip-flop controller.
interface cn_ff_ctrl_if #(parameter int WIDTH = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] shadow;
  logic             busy;
  logic             err;
  logic             err_clr;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_data, err_clr, q_fb,
    input  cmd_ready, c, n, shadow, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_data, err_clr, q_fb,
    output cmd_ready, c, n, shadow, busy, err
  );
endinterface

// File: rtl/cn_bit_enc.sv
// Per-bit encoder: turns an opcode and the expected flip-flop state into
// the C/N drive for that bit and the state it will have afterwards.
module cn_bit_enc
  import cn_ff_ctrl_pkg::*;
(
  input  logic [2:0] op,
  input  logic       mask,
  input  logic       data,
  input  logic       shadow,
  output logic       c,
  output logic       n,
  output logic       next_shadow
);

  // n=0 holds, n=1/c=0 clears, n=1/c=1 toggles the flip-flop
  always_comb begin
    c           = 1'b0;
    n           = 1'b0;
    next_shadow = shadow;
    if (mask) begin
      case (op)
        OP_SET:    begin n = ~shadow;        c = 1'b1; next_shadow = 1'b1;    end
        OP_CLEAR:  begin n = shadow;         c = 1'b0; next_shadow = 1'b0;    end
        OP_TOGGLE: begin n = 1'b1;           c = 1'b1; next_shadow = ~shadow; end
        OP_WRITE:  begin n = shadow ^ data;  c = 1'b1; next_shadow = data;    end
        default:   begin n = 1'b0;           c = 1'b0; next_shadow = shadow;  end
      endcase
    end else begin
      c           = 1'b0;
      n           = 1'b0;
      next_shadow = shadow;
    end
  end

endmodule

// File: rtl/cn_ff_ctrl.sv
// Controller driving a bank of CN flip-flops and tracking their expected state.
// Define CN_FF_CTRL_CHECK_EN to add the CHECK state comparing q_fb with shadow.
module cn_ff_ctrl
  import cn_ff_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  cn_ff_ctrl_if.slave   bus
);

  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);
`ifdef CN_FF_CTRL_CHECK_EN
  localparam state_e ST_AFTER = ST_CHECK;
`else
  localparam state_e ST_AFTER = ST_IDLE;
  logic unused_q_s;
  assign unused_q_s = ^bus.q_fb;
`endif

  state_e                  state_r, state_next_s;
  logic [INIT_CNT_W-1:0]   init_cnt_r;
  logic [2:0]              op_r;
  logic [WIDTH-1:0]        mask_r;
  logic [WIDTH-1:0]        shadow_r, pend_shadow_r;
  logic [WIDTH-1:0]        c_r, n_r;
  logic                    cmd_ready_r, busy_r, err_r;
  logic                    err_set_s;
  logic [2:0]              enc_op_s;
  logic [WIDTH-1:0]        enc_mask_s, enc_data_s, enc_shadow_s;
  logic [WIDTH-1:0]        enc_c_s, enc_n_s, enc_next_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_enc
    cn_bit_enc u_enc (
      .op          (enc_op_s),
      .mask        (enc_mask_s[i]),
      .data        (enc_data_s[i]),
      .shadow      (enc_shadow_s[i]),
      .c           (enc_c_s[i]),
      .n           (enc_n_s[i]),
      .next_shadow (enc_next_s[i])
    );
  end

  // Next state plus the encoding for the phase about to be driven
  always_comb begin
    state_next_s = state_r;
    enc_op_s     = OP_NOP;
    enc_mask_s   = bus.cmd_mask;
    enc_data_s   = bus.cmd_data;
    enc_shadow_s = shadow_r;
    err_set_s    = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (init_cnt_r == INIT_LAST) state_next_s = ST_IDLE;
        else                         state_next_s = ST_INIT;
      end
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_next_s = ST_ISSUE;
          enc_op_s     = issue_op(bus.cmd_op);
          err_set_s    = ~op_legal(bus.cmd_op);
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // The clear phase of PULSE works from the post-SET state
        enc_mask_s   = mask_r;
        enc_shadow_s = pend_shadow_r;
        if (op_r == OP_PULSE) begin
          state_next_s = ST_PULSE2;
          enc_op_s     = OP_CLEAR;
        end else begin
          state_next_s = ST_AFTER;
        end
      end
      ST_PULSE2: state_next_s = ST_AFTER;
`ifdef CN_FF_CTRL_CHECK_EN
      ST_CHECK: begin
        state_next_s = ST_IDLE;
        err_set_s    = (bus.q_fb != shadow_r);
      end
`endif
      default: state_next_s = ST_INIT;
    endcase
  end

  // State, command capture, shadow tracking and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_INIT;
      init_cnt_r    <= '0;
      op_r          <= OP_NOP;
      mask_r        <= '0;
      shadow_r      <= '0;
      pend_shadow_r <= '0;
      c_r           <= '0;
      n_r           <= '1;
      cmd_ready_r   <= 1'b0;
      busy_r        <= 1'b1;
      err_r         <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      init_cnt_r <= (state_r == ST_INIT) ? init_cnt_r + INIT_CNT_W'(1) : '0;
      if (state_r == ST_IDLE && bus.cmd_valid) begin
        op_r   <= bus.cmd_op;
        mask_r <= bus.cmd_mask;
      end
      if (state_next_s == ST_ISSUE || state_next_s == ST_PULSE2)
        pend_shadow_r <= enc_next_s;
      if (state_r == ST_ISSUE || state_r == ST_PULSE2)
        shadow_r <= pend_shadow_r;
      case (state_next_s)
        ST_INIT:             begin c_r <= '0;      n_r <= '1;      end
        ST_ISSUE, ST_PULSE2: begin c_r <= enc_c_s; n_r <= enc_n_s; end
        default:             begin c_r <= '0;      n_r <= '0;      end
      endcase
      cmd_ready_r <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      if (err_set_s)        err_r <= 1'b1;
      else if (bus.err_clr) err_r <= 1'b0;
      else                  err_r <= err_r;
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.c         = c_r;
  assign bus.n         = n_r;
  assign bus.shadow    = shadow_r;
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;

endmodule
